seg_dynamic: RTL and testbench

Dynamic-scan front end for the six-digit seven-segment display. It takes a 20-bit unsigned binary value plus a sign flag and a decimal-point mask, converts the value to BCD with a sequential converter, and applies leading-zero blanking. It time-multiplexes the digits and drives the `sel`/`seg` byte pair consumed directly by `hc595_ctrl`, which serialises that pair into the 74HC595 chain.

---
 rtl/seg_pkg.sv | 49 ++++
 rtl/seg_dynamic_if.sv | 21 ++
 rtl/bin2bcd.sv | 67 ++++++
 rtl/seg_dynamic.sv | 118 +++++++++++
 tb/tb_seg_dynamic.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants, converter state type and digit-to-segment lookup for the
// dynamic seven-segment scan front end.
package seg_pkg;

  localparam int          DIGITS      = 6;
  localparam int          BIN_W       = 20;
  localparam int          BCD_W       = 4 * DIGITS;
  localparam int          CNT_MAX_DEF = 49_999;
  localparam logic [19:0] DATA_MAX    = 20'd999_999;

  // Active-low patterns, bit 7 = dp, bits 6:0 = g..a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_dynamic_if.sv
// Value/format inputs and the sel/seg byte pair handed on to hc595_ctrl.
interface seg_dynamic_if;

  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [7:0]  sel;
  logic [7:0]  seg;

  modport master (
    output data, point, sign, seg_en,
    input  sel, seg
  );

  modport slave (
    input  data, point, sign, seg_en,
    output sel, seg
  );

endinterface

// File: rtl/bin2bcd.sv
// Free-running sequential double-dabble converter: 20-bit binary to six BCD
// digits, one conversion every 22 clocks with a one-cycle bcd_valid strobe.
module bin2bcd
  import seg_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [BIN_W-1:0]  bin,
  output logic [BCD_W-1:0]  bcd,
  output logic              bcd_valid
);

  conv_state_t       state;
  conv_state_t       state_nxt;
  logic [4:0]        iter_cnt;
  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  bcd_sr;
  logic [BCD_W-1:0]  bcd_adj;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SHIFT;
      SHIFT:   if (iter_cnt == 5'(BIN_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
    end
  end

  // Adjust-then-shift on the combined {bcd, bin} register, one bit per clock
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      iter_cnt <= '0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bin_sr   <= bin;
          bcd_sr   <= '0;
          iter_cnt <= '0;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          iter_cnt         <= iter_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd       = bcd_sr;
  assign bcd_valid = (state == DONE);

endmodule

// File: rtl/seg_dynamic.sv
// Six-digit dynamic-scan front end: clamp, BCD conversion, frame-aligned
// display commit, leading-zero blanking with sign, and registered sel/seg.
module seg_dynamic
  import seg_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input logic          sys_clk,
  input logic          sys_rst,
  seg_dynamic_if.slave bus
);

  localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [BIN_W-1:0]  data_clamped;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_valid;
  logic [BCD_W-1:0]  pend_bcd;
  logic              pend_flag;
  logic [BCD_W-1:0]  disp_bcd;
  logic [DIGITS-1:0] disp_point;
  logic              disp_sign;
  logic [CNT_W-1:0]  cnt_dwell;
  logic [2:0]        cnt_sel;
  logic              dwell_end;
  logic              commit;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] minus_mask;
  logic              nonzero_above;
  logic [7:0]        pattern;
  logic [7:0]        sel_nxt;
  logic [7:0]        seg_nxt;
  logic [7:0]        sel_q;
  logic [7:0]        seg_q;

  assign data_clamped = (bus.data > DATA_MAX) ? DATA_MAX : bus.data;

  bin2bcd u_bin2bcd (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .bin       (data_clamped),
    .bcd       (conv_bcd),
    .bcd_valid (conv_valid)
  );

  assign dwell_end = (cnt_dwell == CNT_W'(CNT_MAX));
  assign commit    = dwell_end && (cnt_sel == 3'(DIGITS - 1)) && pend_flag;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_dwell <= '0;
      cnt_sel   <= '0;
    end else if (dwell_end) begin
      cnt_dwell <= '0;
      cnt_sel   <= (cnt_sel == 3'(DIGITS - 1)) ? 3'd0 : cnt_sel + 3'd1;
    end else begin
      cnt_dwell <= cnt_dwell + CNT_W'(1);
    end
  end

  // Display only changes on the 5->0 wrap so a frame never mixes two values;
  // a result arriving on that same edge waits in pending for the next frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_bcd   <= '0;
      pend_flag  <= 1'b0;
      disp_bcd   <= '0;
      disp_point <= '0;
      disp_sign  <= 1'b0;
    end else begin
      if (conv_valid) pend_bcd <= conv_bcd;
      if (conv_valid)  pend_flag <= 1'b1;
      else if (commit) pend_flag <= 1'b0;
      if (commit) begin
        disp_bcd   <= pend_bcd;
        disp_point <= bus.point;
        disp_sign  <= bus.sign;
      end
    end
  end

  always_comb begin
    blank         = '0;
    minus_mask    = '0;
    nonzero_above = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nonzero_above = nonzero_above | (disp_bcd[4*i +: 4] != 4'd0);
      blank[i]      = ~nonzero_above;
    end
    for (int i = 1; i < DIGITS; i++) begin
      minus_mask[i] = disp_sign & blank[i] & ~blank[i-1];
    end
  end

  always_comb begin
    pattern = seg_pattern(disp_bcd[{cnt_sel, 2'b00} +: 4]);
    if (blank[cnt_sel]) pattern = minus_mask[cnt_sel] ? SEG_MINUS : SEG_BLANK;
    seg_nxt = {pattern[7] & ~disp_point[cnt_sel], pattern[6:0]};
    sel_nxt = 8'h01 << cnt_sel;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q <= 8'h00;
      seg_q <= SEG_BLANK;
    end else if (bus.seg_en) begin
      sel_q <= sel_nxt;
      seg_q <= seg_nxt;
    end else begin
      sel_q <= 8'h00;
      seg_q <= SEG_BLANK;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic.sv
// Directed, table-driven bench for seg_dynamic with a 10-cycle digit dwell.
module tb_seg_dynamic;

  localparam int CNT_MAX = 9;
  localparam int DWELL   = CNT_MAX + 1;

  typedef struct packed {
    logic [19:0]     data;
    logic [5:0]      point;
    logic            sign;
    logic [5:0][7:0] exp_seg;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   checks = 0;
  int   fails  = 0;

  seg_dynamic_if bus ();

  seg_dynamic #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] d, input logic [5:0] p, input logic s);
    @(negedge sys_clk);
    bus.data  = d;
    bus.point = p;
    bus.sign  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Returns on the first negedge of a fresh dwell of the target digit
  task automatic waitSel(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (bus.sel !== target) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (ok) begin
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge sys_clk);
        if (bus.sel === target) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("[TB] FAIL wait_sel: timed out, sel=%0h expected %0h", bus.sel, target);
    end
  endtask

  task automatic captureFrame(output logic [5:0][7:0] got);
    bit         ok;
    logic [7:0] target;
    for (int i = 0; i < 6; i++) begin
      target = 8'h01 << i;
      waitSel(target, ok);
      got[i] = ok ? bus.seg : 8'hxx;
    end
  endtask

  task automatic checkFrame(input string name, input logic [5:0][7:0] got, input logic [5:0][7:0] exp);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("%s_d%0d", name, i), got[i], exp[i]);
  endtask

  vec_t            vecs [9];
  logic [5:0][7:0] frame;
  logic [5:0][7:0] old_frame;
  logic [5:0][7:0] new_frame;
  bit              ok;
  bit              seen_new;
  int              dwell;
  logic [7:0]      target;

  initial begin
    vecs[0] = '{20'd0,       6'b000000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[1] = '{20'd1234,    6'b000100, 1'b1, {8'hFF, 8'hBF, 8'hF9, 8'h24, 8'hB0, 8'h99}};
    vecs[2] = '{20'd1048575, 6'b000000, 1'b1, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3] = '{20'd0,       6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0}};
    vecs[4] = '{20'd999999,  6'b111111, 1'b0, {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10}};
    vecs[5] = '{20'd100000,  6'b000000, 1'b0, {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[6] = '{20'd50,      6'b010001, 1'b1, {8'hFF, 8'h7F, 8'hFF, 8'hBF, 8'h92, 8'h40}};
    vecs[7] = '{20'd99999,   6'b000000, 1'b1, {8'hBF, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[8] = '{20'd1000000, 6'b100000, 1'b0, {8'h10, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};

    sys_rst    = 1'b1;
    bus.data   = 20'd0;
    bus.point  = 6'b0;
    bus.sign   = 1'b0;
    bus.seg_en = 1'b1;
    #1;
    checkOutput("reset_sel", bus.sel, 8'h00);
    checkOutput("reset_seg", bus.seg, 8'hFF);
    idle(3);
    sys_rst = 1'b0;

    captureFrame(frame);
    checkFrame("reset_frame", frame, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    waitSel(8'h01, ok);
    dwell = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge sys_clk);
      if (bus.sel !== 8'h01) break;
      dwell++;
    end
    checkOutput("dwell_d0", dwell, DWELL);

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].data, vecs[v].point, vecs[v].sign);
      idle(200);
      captureFrame(frame);
      checkFrame($sformatf("vec%0d", v), frame, vecs[v].exp_seg);
    end

    // Change 5 -> 700000 while digit 2 is on screen; every frame must be whole
    old_frame = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92};
    new_frame = {8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    applyStimulus(20'd5, 6'b0, 1'b0);
    idle(200);
    waitSel(8'h04, ok);
    applyStimulus(20'd700000, 6'b0, 1'b0);
    for (int i = 3; i < 6; i++) begin
      target = 8'h01 << i;
      waitSel(target, ok);
      checkOutput($sformatf("midframe_tail_d%0d", i), bus.seg, old_frame[i]);
    end
    seen_new = 1'b0;
    for (int f = 0; f < 4; f++) begin
      captureFrame(frame);
      checks++;
      if (!((frame == old_frame) || (frame == new_frame)) || (seen_new && frame != new_frame)) begin
        fails++;
        $display("[TB] FAIL frame_coherent_%0d: got %0h, expected %0h or %0h", f, frame, old_frame, new_frame);
      end
      if (frame == new_frame) seen_new = 1'b1;
    end
    checkFrame("midframe_final", frame, new_frame);

    // Blank for 15 cycles starting on the first cycle of digit 1
    waitSel(8'h02, ok);
    bus.seg_en = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge sys_clk);
      checkOutput($sformatf("disabled_sel_%0d", k), bus.sel, 8'h00);
      checkOutput($sformatf("disabled_seg_%0d", k), bus.seg, 8'hFF);
    end
    bus.seg_en = 1'b1;
    @(negedge sys_clk);
    checkOutput("reenable_sel", bus.sel, 8'h04);
    checkOutput("reenable_seg", bus.seg, 8'hC0);
    idle(4);
    checkOutput("reenable_next_sel", bus.sel, 8'h08);

    // Async reset while converting: outputs clear before any clock edge
    applyStimulus(20'd42, 6'b000010, 1'b1);
    idle(200);
    captureFrame(frame);
    checkFrame("pre_reset", frame, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h19, 8'hA4});
    idle(7);
    #2 sys_rst = 1'b1;
    #1;
    checkOutput("async_reset_sel", bus.sel, 8'h00);
    checkOutput("async_reset_seg", bus.seg, 8'hFF);
    idle(3);
    sys_rst = 1'b0;
    captureFrame(frame);
    checkFrame("post_reset_frame1", frame, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    captureFrame(frame);
    checkFrame("post_reset_frame2", frame, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h19, 8'hA4});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
